// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_unit_pkg;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } ifetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [31:0]       pc;
  } ifetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory bus, redirect input and decode handshake of ifetch_unit.
interface ifetch_unit_if;

  logic                               imem_req_o;
  logic [31:0]                        imem_addr_o;
  logic                               imem_ack_i;
  logic [ifetch_unit_pkg::INST_W-1:0] imem_rdata_i;
  logic                               redirect_i;
  logic [31:0]                        redirect_pc_i;
  logic                               inst_valid_o;
  logic                               inst_ready_i;
  logic [ifetch_unit_pkg::INST_W-1:0] inst_o;
  logic [31:0]                        pc_o;
  logic [31:0]                        pc4_o;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ack_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o, pc_o, pc4_o
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ack_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o, pc_o, pc4_o
  );

endinterface

// File: rtl/ifetch_buf.sv
// Shift-register FIFO of {inst, pc}; head entry comes straight from flops.
// Push and pop may coincide, also when full; flush empties it.
module ifetch_buf
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  ifetch_entry_t    wdata,
  output ifetch_entry_t    head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  ifetch_entry_t    ent     [DEPTH];
  ifetch_entry_t    ent_nxt [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] wr_idx;

  // Shift on pop, then write the new entry just above the surviving ones
  always_comb begin
    wr_idx = cnt_q - CNT_W'(pop);
    for (int unsigned i = 0; i < DEPTH; i++) ent_nxt[i] = ent[i];
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) ent_nxt[i] = ent[i + 1];
    end
    if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_idx == CNT_W'(i)) ent_nxt[i] = wdata;
      end
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (flush) cnt_q <= '0;
      else       cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
    end
  end

  assign head  = ent[0];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over req/ack, buffers
// {inst, pc} toward decode and handles redirects.
// Optional build macro IFETCH_STATS_EN adds fetch/redirect counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef IFETCH_STATS_EN
  output logic [31:0] stat_fetch_o,
  output logic [31:0] stat_flush_o,
`endif
  ifetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  ifetch_state_t    state, state_nxt;
  logic [31:0]      fetch_pc, fetch_pc_nxt, addr_q;
  logic [CNT_W-1:0] occ;
  logic [OCC_W-1:0] occ_after;
  logic             push, pop, valid, has_room;
  ifetch_entry_t    head, wdata;

  // An ack is buffered only in REQ and only when no redirect discards it
  assign push      = (state == REQ) && bus.imem_ack_i && !bus.redirect_i;
  assign pop       = valid && bus.inst_ready_i;
  assign occ_after = OCC_W'(occ) + OCC_W'(push) - OCC_W'(pop);
  assign has_room  = occ_after < OCC_W'(BUF_DEPTH);
  assign wdata     = '{inst: bus.imem_rdata_i, pc: fetch_pc};

  // Next fetch state and PC; a redirect overrides the normal sequencing
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    case (state)
      IDLE: if (has_room) state_nxt = REQ;
      REQ: begin
        if (bus.imem_ack_i) begin
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = has_room ? REQ : IDLE;
        end
      end
      DROP: if (bus.imem_ack_i) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (bus.redirect_i) begin
      fetch_pc_nxt = bus.redirect_pc_i & 32'hFFFF_FFFC;
      state_nxt    = (state != IDLE && !bus.imem_ack_i) ? DROP : REQ;
    end
  end

  // State, fetch PC and bus address; the address is frozen while a stale
  // request is being drained so the bus sees a stable address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (state_nxt != DROP) addr_q <= fetch_pc_nxt;
    end
  end

  ifetch_buf #(
    .DEPTH (BUF_DEPTH),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk   (clk),
    .rst   (reset),
    .flush (bus.redirect_i),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .head  (head),
    .valid (valid),
    .count (occ)
  );

  assign bus.imem_req_o   = (state != IDLE);
  assign bus.imem_addr_o  = addr_q;
  assign bus.inst_valid_o = valid;
  assign bus.inst_o       = head.inst;
  assign bus.pc_o         = head.pc;
  assign bus.pc4_o        = valid ? head.pc + 32'd4 : '0;

`ifdef IFETCH_STATS_EN
  // Wrapping counters of buffered fetches and redirects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_fetch_o <= '0;
      stat_flush_o <= '0;
    end else begin
      if (push)           stat_fetch_o <= stat_fetch_o + 32'd1;
      if (bus.redirect_i) stat_flush_o <= stat_flush_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus a random run
// against a queue-based reference model of the fetch/deliver rules.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  ifetch_unit_if bus ();

`ifdef IFETCH_STATS_EN
  logic [31:0] stat_fetch, stat_flush;
`endif

  ifetch_unit #(
    .RESET_PC  (RESET_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef IFETCH_STATS_EN
    .stat_fetch_o (stat_fetch),
    .stat_flush_o (stat_flush),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        q[$];
  logic [31:0] acc_addr[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_pc4[$];
  logic [31:0] m_fetch;
  bit          drop_pending;
  int unsigned age, lat, guard;
  int unsigned m_nfetch, m_nflush;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] qq[$], input int idx);
    return (idx < qq.size()) ? qq[idx] : 32'hDEAD_BEEF;
  endfunction

  task automatic model_reset();
    q.delete();
    m_fetch      = RESET_PC;
    drop_pending = 0;
    age          = 0;
    m_nfetch     = 0;
    m_nflush     = 0;
  endtask

  // One cycle, entered and left at posedge+1: check outputs, drive inputs,
  // advance the reference model, wait for the next edge.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
    logic        req, valid, ack;
    logic [31:0] addr;
    req   = bus.imem_req_o;
    addr  = bus.imem_addr_o;
    valid = bus.inst_valid_o;
    chk("valid", valid, q.size() != 0);
    if (valid && q.size() != 0) begin
      chk("inst", bus.inst_o, q[0].inst);
      chk("pc",   bus.pc_o,   q[0].pc);
      chk("pc4",  bus.pc4_o,  q[0].pc + 32'd4);
    end
    if (req && !drop_pending) chk("addr", addr, m_fetch);
    chk("credit", (q.size() + ((req && !drop_pending) ? 1 : 0)) <= DEPTH, 1);
    if (req) begin
      ack = (age >= lat);
      age = ack ? 0 : age + 1;
    end else begin
      ack = 1'b0;
      age = 0;
    end
    bus.imem_ack_i    = ack;
    bus.imem_rdata_i  = ack ? mem_word(addr) : $urandom;
    bus.inst_ready_i  = rdy;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = redir ? rpc : $urandom;
    if (valid && rdy && q.size() != 0) begin
      got_pc.push_back(bus.pc_o);
      got_pc4.push_back(bus.pc4_o);
      void'(q.pop_front());
    end
    if (req && ack) begin
      if (drop_pending) drop_pending = 0;
      else if (!redir) begin
        q.push_back('{inst: mem_word(m_fetch), pc: m_fetch});
        acc_addr.push_back(m_fetch);
        m_fetch = m_fetch + 32'd4;
        m_nfetch++;
      end
    end
    if (redir) begin
      q.delete();
      m_fetch      = rpc & 32'hFFFF_FFFC;
      drop_pending = req && !ack;
      m_nflush++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.imem_ack_i    = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.inst_ready_i  = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   bus.imem_req_o,   0);
    chk("rst_valid", bus.inst_valid_o, 0);
    chk("rst_inst",  bus.inst_o,       0);
    chk("rst_pc",    bus.pc_o,         0);
    chk("rst_pc4",   bus.pc4_o,        0);
    reset = 1'b0;
    model_reset();
    acc_addr.delete();
    got_pc.delete();
    got_pc4.delete();
  endtask

  initial begin
    // 1: steady fetch with one-cycle ack latency
    do_reset();
    lat = 1;
    repeat (14) step(1'b1, 1'b0, '0);
    chk("t1_count", got_pc.size() >= 4, 1);
    chk("t1_pc0", at(got_pc, 0), 32'h0);
    chk("t1_pc1", at(got_pc, 1), 32'h4);
    chk("t1_pc2", at(got_pc, 2), 32'h8);
    chk("t1_pc3", at(got_pc, 3), 32'hC);
    chk("t1_pc4_0", at(got_pc4, 0), 32'h4);

    // 2: back-pressure stops fetching at the buffer depth
    do_reset();
    lat = 1;
    repeat (10) step(1'b0, 1'b0, '0);
    chk("t2_nfetch", m_nfetch, DEPTH);
    chk("t2_req", bus.imem_req_o, 0);
    chk("t2_valid", bus.inst_valid_o, 1);
    got_pc.delete();
    acc_addr.delete();
    repeat (8) step(1'b1, 1'b0, '0);
    chk("t2_pc0", at(got_pc, 0), 32'h0);
    chk("t2_pc1", at(got_pc, 1), 32'h4);
    chk("t2_resume", at(acc_addr, 0), 32'h8);

    // 3: redirect while the 0x8 request waits for a late ack
    do_reset();
    lat   = 1;
    guard = 0;
    while (!(bus.imem_req_o && bus.imem_addr_o == 32'h8 && age == 0) && guard < 30) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
    chk("t3_find", guard < 30, 1);
    lat = 3;
    step(1'b1, 1'b1, 32'h100);
    chk("t3_drop_req",  bus.imem_req_o,  1);
    chk("t3_drop_addr", bus.imem_addr_o, 32'h8);
    acc_addr.delete();
    got_pc.delete();
    repeat (12) step(1'b1, 1'b0, '0);
    chk("t3_addr", at(acc_addr, 0), 32'h100);
    chk("t3_pc",   at(got_pc, 0),   32'h100);

    // 4: redirect coinciding with an ack
    do_reset();
    lat = 1;
    repeat (5) step(1'b1, 1'b0, '0);
    guard = 0;
    while (!(bus.imem_req_o && age >= lat && !drop_pending) && guard < 10) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
    chk("t4_find", guard < 10, 1);
    step(1'b1, 1'b1, 32'h203);
    chk("t4_req",  bus.imem_req_o,  1);
    chk("t4_addr", bus.imem_addr_o, 32'h200);
    acc_addr.delete();
    repeat (6) step(1'b1, 1'b0, '0);
    chk("t4_first", at(acc_addr, 0), 32'h200);

    // 5: PC wrap
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    acc_addr.delete();
    got_pc.delete();
    got_pc4.delete();
    repeat (12) step(1'b1, 1'b0, '0);
    chk("t5_a0",  at(acc_addr, 0), 32'hFFFF_FFFC);
    chk("t5_a1",  at(acc_addr, 1), 32'h0);
    chk("t5_pc",  at(got_pc, 0),   32'hFFFF_FFFC);
    chk("t5_n",   got_pc4.size() >= 1, 1);
    chk("t5_pc4", at(got_pc4, 0),  32'h0);

    // 6: reset between request and ack, late ack ignored
    lat = 1;
    repeat (4) step(1'b1, 1'b0, '0);
    guard = 0;
    while (!(bus.imem_req_o && age == 0 && !drop_pending) && guard < 10) begin
      step(1'b1, 1'b0, '0);
      guard++;
    end
    chk("t6_find", guard < 10, 1);
    reset = 1'b1;
    #1;
    chk("t6_req",   bus.imem_req_o,   0);
    chk("t6_valid", bus.inst_valid_o, 0);
    chk("t6_inst",  bus.inst_o,       0);
    chk("t6_pc",    bus.pc_o,         0);
    chk("t6_pc4",   bus.pc4_o,        0);
    bus.imem_ack_i   = 1'b1;
    bus.imem_rdata_i = 32'hBAD0_BAD0;
    bus.redirect_i   = 1'b0;
    bus.inst_ready_i = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    acc_addr.delete();
    @(posedge clk);
    #1;
    bus.imem_ack_i = 1'b0;
    chk("t6_late_valid", bus.inst_valid_o, 0);
    chk("t6_first_req",  bus.imem_req_o,   1);
    chk("t6_first_addr", bus.imem_addr_o,  RESET_PC);
`ifdef IFETCH_STATS_EN
    chk("t6_stat_fetch", stat_fetch, 0);
`endif
    repeat (6) step(1'b1, 1'b0, '0);
    chk("t6_acc", at(acc_addr, 0), RESET_PC);

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      bit          rdy, redir;
      if (age == 0) lat = $urandom_range(0, 3);
      rdy   = ($urandom_range(0, 99) < 70);
      redir = ($urandom_range(0, 99) < 4);
      rpc   = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      step(rdy, redir, rpc);
    end
    chk("rand_progress", got_pc.size() > 200, 1);
`ifdef IFETCH_STATS_EN
    chk("rand_stat_fetch", stat_fetch, m_nfetch);
    chk("rand_stat_flush", stat_flush, m_nflush);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
